// File: rtl/mem_burst_master.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_burst_master                                                          |
// | Burst read/write initiator for a byte-wide memory with falling-edge       |
// | writes and combinational reads. Optional macro: MEM_BURST_WRAP_EN lets    |
// | bursts wrap past the top address instead of being rejected.               |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module mem_burst_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  output logic              o_cmd_err,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [1:0]        c_IDLE     = 2'd0;
  localparam logic [1:0]        c_READ     = 2'd1;
  localparam logic [1:0]        c_WRITE    = 2'd2;
  localparam logic [LEN_W:0]    c_BEAT_ONE = (LEN_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

  logic [1:0]        r_state;
  logic [LEN_W:0]    r_remaining;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_beat_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_done;
  logic              r_cmd_err;

  logic              w_cmd_reject;
  logic [LEN_W:0]    w_len_beats;
  logic              w_wr_ready;
  logic              w_wr_fire;
  logic              w_rd_capture;
  logic              w_rd_last;

`ifdef MEM_BURST_WRAP_EN
  assign w_cmd_reject = 1'b0;
`else
  // A burst whose last beat would pass the top address is refused outright.
  localparam logic [ADDR_W:0] c_ADDR_TOP = {1'b0, {ADDR_W{1'b1}}};
  logic [ADDR_W:0] w_cmd_end;
  assign w_cmd_end    = {1'b0, i_cmd_addr} + (ADDR_W+1)'(i_cmd_len);
  assign w_cmd_reject = (w_cmd_end > c_ADDR_TOP);
`endif

  assign w_len_beats  = (LEN_W+1)'(i_cmd_len) + c_BEAT_ONE;
  assign w_wr_ready   = (r_state == c_WRITE) && (r_remaining != '0);
  assign w_wr_fire    = i_wr_valid && w_wr_ready;
  // Capture when the single output slot is free or being drained this edge.
  assign w_rd_capture = (r_state == c_READ) && (r_remaining != '0) &&
                        (!r_rd_valid || i_rd_ready);
  assign w_rd_last    = (r_state == c_READ) && (r_remaining == '0) &&
                        r_rd_valid && i_rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_remaining <= '0;
      r_mem_addr  <= '0;
      r_beat_addr <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_done      <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cmd_err <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (i_cmd_valid) begin
            if (w_cmd_reject) begin
              r_cmd_err <= 1'b1;
            end else begin
              r_state     <= i_cmd_write ? c_WRITE : c_READ;
              r_mem_addr  <= i_cmd_addr;
              r_beat_addr <= i_cmd_addr;
              r_remaining <= w_len_beats;
            end
          end
        end
        c_READ: begin
          if (w_rd_capture) begin
            r_rd_data   <= i_mem_rdata;
            r_rd_valid  <= 1'b1;
            r_mem_addr  <= r_mem_addr + c_ADDR_ONE;
            r_remaining <= r_remaining - c_BEAT_ONE;
          end else if (w_rd_last) begin
            r_rd_valid <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= c_IDLE;
          end
        end
        c_WRITE: begin
          if (r_remaining != '0) begin
            if (w_wr_fire) begin
              r_mem_addr  <= r_beat_addr;
              r_mem_wdata <= i_wr_data;
              r_mem_we    <= 1'b1;
              r_beat_addr <= r_beat_addr + c_ADDR_ONE;
              r_remaining <= r_remaining - c_BEAT_ONE;
            end else begin
              r_mem_we <= 1'b0;
            end
          end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = (r_state == c_IDLE);
  assign o_cmd_err   = r_cmd_err;
  assign o_wr_ready  = w_wr_ready;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_done      = r_done;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we    = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_master.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mem_burst_master                                                       |
// | Self-checking bench: vector table, hand sequences and random bursts       |
// | against a byte-array reference model. Honours MEM_BURST_WRAP_EN.          |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_mem_burst_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write, cmd_err;
  logic [7:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       done;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  mem_burst_master #(.ADDR_W(8), .DATA_W(8), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .o_cmd_err(cmd_err),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
    .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
    .o_done(done),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata)
  );

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [3:0] len;
    logic [7:0] base;
    int         mode;
    bit         exp_err;
    logic [7:0] exp_first;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_mem();
    int bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) bad++;
    check("memory_contents", bad, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_cmd_err",   cmd_err,   0);
    check("rst_wr_ready",  wr_ready,  0);
    check("rst_rd_valid",  rd_valid,  0);
    check("rst_rd_data",   rd_data,   0);
    check("rst_done",      done,      0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_we",    mem_we,    0);
  endtask

  function automatic bit model_reject(input logic [7:0] addr, input logic [3:0] len);
`ifdef MEM_BURST_WRAP_EN
    return 1'b0;
`else
    return (int'(addr) + int'(len)) > 255;
`endif
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 in the done cycle.
  // mode: 0 = continuous, 1 = write every other cycle / read stall 3 cycles on beat 2,
  // 2 = random valid/ready.
  task automatic run_burst(input bit wr, input logic [7:0] addr, input logic [3:0] len,
                           input logic [7:0] base, input int mode, input bit exp_err,
                           output logic [7:0] first);
    int nb = int'(len) + 1;
    int c = 0;
    int i = 0;
    int j = 0;
    int stall = 0;
    int captured;
    bit hs, lastbeat, got_done;
    logic [7:0] exp_q [16];
    first = 8'h00;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_len = 4'($urandom);
    check("done_cleared", done, 0);
    check("cmd_err", cmd_err, exp_err);
    if (exp_err) begin
      check("ready_after_err", cmd_ready, 1);
      check("we_after_err", mem_we, 0);
      @(posedge clk); #1;
      check("err_one_cycle", cmd_err, 0);
      check("no_done_after_err", done, 0);
      check_mem();
      return;
    end
    check("cmd_ready_busy", cmd_ready, 0);
    if (wr) begin
      for (int k = 0; k < nb; k++) ref_mem[(int'(addr) + k) % 256] = base + 8'(k);
      while (i < nb && c < 200) begin
        case (mode)
          0:       wr_valid = 1'b1;
          1:       wr_valid = (c % 2 == 0);
          default: wr_valid = ($urandom_range(0, 2) != 0);
        endcase
        wr_data  = base + 8'(i);
        rd_ready = 1'($urandom);
        check("wr_ready_open", wr_ready, 1);
        hs = wr_valid;
        @(posedge clk); #1; c++;
        if (hs) begin
          check("wr_mem_we", mem_we, 1);
          check("wr_mem_addr", mem_addr, (int'(addr) + i) % 256);
          check("wr_mem_wdata", mem_wdata, base + 8'(i));
          i++;
        end else begin
          check("wr_no_we_on_gap", mem_we, 0);
        end
        check("wr_no_early_done", done, 0);
        check("rd_valid_in_write", rd_valid, 0);
      end
      wr_valid = 1'b0; rd_ready = 1'b0;
      if (i < nb) begin
        check("wr_timeout_beats", i, nb);
        return;
      end
      check("wr_ready_closed", wr_ready, 0);
      @(posedge clk); #1; c++;
      check("wr_done", done, 1);
      check("wr_we_low_at_done", mem_we, 0);
      check("wr_ready_at_done", cmd_ready, 1);
      if (mode == 0) check("wr_done_latency", c, nb + 1);
      check_mem();
    end else begin
      for (int k = 0; k < nb; k++) exp_q[k] = ref_mem[(int'(addr) + k) % 256];
      got_done = 1'b0;
      check("rd_not_valid_at_accept", rd_valid, 0);
      while (!got_done && c < 200) begin
        if (c == 1) check("rd_first_latency", rd_valid, 1);
        captured = j + (rd_valid ? 1 : 0);
        check("rd_mem_addr", mem_addr, (int'(addr) + captured) % 256);
        check("rd_no_we", mem_we, 0);
        case (mode)
          0: rd_ready = 1'b1;
          1: if (j == 1 && stall < 3) begin rd_ready = 1'b0; stall++; end
             else rd_ready = 1'b1;
          default: rd_ready = ($urandom_range(0, 2) != 0);
        endcase
        wr_valid = 1'($urandom); wr_data = 8'($urandom);
        if (mode == 0 && c >= 1) check("rd_sustained", rd_valid, 1);
        if (rd_valid) begin
          if (j < nb) begin
            check("rd_data", rd_data, exp_q[j]);
            if (j == 0) first = rd_data;
          end else begin
            check("rd_extra_beat", rd_valid, 0);
          end
        end
        hs = rd_valid && rd_ready;
        lastbeat = hs && (j == nb - 1);
        if (hs) j++;
        @(posedge clk); #1; c++;
        if (lastbeat) begin
          check("rd_done", done, 1);
          check("rd_valid_drop", rd_valid, 0);
          check("rd_ready_at_done", cmd_ready, 1);
          if (mode == 0) check("rd_done_latency", c, nb + 1);
          got_done = 1'b1;
        end else begin
          check("rd_no_early_done", done, 0);
        end
      end
      rd_ready = 1'b0; wr_valid = 1'b0;
      if (!got_done) check("rd_timeout_done", got_done, 1);
    end
  endtask

  initial begin
    logic [7:0] first;
    bit         wr;
    logic [7:0] a, b;
    logic [3:0] l;

    for (int k = 0; k < 256; k++) begin
      mem[k]     = 8'(k) ^ 8'h5A;
      ref_mem[k] = 8'(k) ^ 8'h5A;
    end
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    vecs[0]  = '{1'b1, 8'h10, 4'd3,  8'hA1, 0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h10, 4'd3,  8'h00, 0, 1'b0, 8'hA1};
    vecs[2]  = '{1'b0, 8'h10, 4'd3,  8'h00, 1, 1'b0, 8'hA1};
    vecs[3]  = '{1'b1, 8'h20, 4'd3,  8'h31, 1, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 8'h20, 4'd3,  8'h00, 0, 1'b0, 8'h31};
`ifdef MEM_BURST_WRAP_EN
    vecs[5]  = '{1'b1, 8'hFE, 4'd2,  8'hC1, 0, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 8'hFE, 4'd1,  8'h00, 0, 1'b0, 8'hC1};
    vecs[7]  = '{1'b0, 8'h00, 4'd0,  8'h00, 0, 1'b0, 8'hC3};
    vecs[10] = '{1'b0, 8'hF8, 4'd8,  8'h00, 0, 1'b0, 8'h09};
`else
    vecs[5]  = '{1'b1, 8'hFE, 4'd2,  8'hC1, 0, 1'b1, 8'h00};
    vecs[6]  = '{1'b0, 8'hFE, 4'd1,  8'h00, 0, 1'b0, 8'hA4};
    vecs[7]  = '{1'b0, 8'h00, 4'd0,  8'h00, 0, 1'b0, 8'h5A};
    vecs[10] = '{1'b0, 8'hF8, 4'd8,  8'h00, 0, 1'b1, 8'h00};
`endif
    vecs[8]  = '{1'b1, 8'hF0, 4'd15, 8'h01, 0, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 8'hF1, 4'd14, 8'h00, 0, 1'b0, 8'h02};

    foreach (vecs[v]) begin
      run_burst(vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].base,
                vecs[v].mode, vecs[v].exp_err, first);
      if (!vecs[v].wr && !vecs[v].exp_err) check("vec_first_beat", first, vecs[v].exp_first);
    end

    for (int r = 0; r < 30; r++) begin
      wr = 1'($urandom);
      a  = 8'($urandom);
      l  = 4'($urandom);
      b  = 8'($urandom);
      run_burst(wr, a, l, b, 2, model_reject(a, l), first);
    end

    // Reset lands after the second beat's write-enable edge, before its commit.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_len = 4'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h51;
    @(posedge clk); #1;
    check("mid_beat0_we", mem_we, 1);
    check("mid_beat0_addr", mem_addr, 8'h40);
    wr_data = 8'h52;
    @(posedge clk); #1;
    check("mid_beat1_we", mem_we, 1);
    ref_mem[8'h40] = 8'h51;
    rst_n = 1'b0; wr_valid = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_mem();
    run_burst(1'b0, 8'h40, 4'd3, 8'h00, 0, 1'b0, first);
    check("post_reset_first", first, 8'h51);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
